// File: rtl/trace_pkg.sv
// trace_pkg: trace record layout, byte indices and serializer states shared by
// bus_cycle_capture and its FIFO.
package trace_pkg;

    localparam int SEQ_BITS = 6;

    typedef struct packed {
        logic [SEQ_BITS-1:0] seq;
        logic                sync;
        logic                rnw;
        logic [15:0]         addr;
        logic [7:0]          data;
    } trace_rec_t;

    localparam logic [1:0] BYTE_DATA    = 2'd0;
    localparam logic [1:0] BYTE_ADDR_LO = 2'd1;
    localparam logic [1:0] BYTE_ADDR_HI = 2'd2;
    localparam logic [1:0] BYTE_FLAGS   = 2'd3;

    typedef enum logic [2:0] {ST_IDLE, ST_B0, ST_B1, ST_B2, ST_B3} state_t;

    function automatic logic [7:0] rec_byte(input trace_rec_t rec, input logic [1:0] idx);
        return idx == BYTE_DATA    ? rec.data :
               idx == BYTE_ADDR_LO ? rec.addr[7:0] :
               idx == BYTE_ADDR_HI ? rec.addr[15:8] :
                                     {rec.seq, rec.sync, rec.rnw};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous record FIFO with a combinational head and an
// occupancy count one bit wider than the address to tell full from empty.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int FIFO_ADDR_BITS = 4
) (
    input  logic                    clk,
    input  logic                    resb,
    input  logic                    push,
    input  trace_rec_t              din,
    input  logic                    pop,
    output trace_rec_t              head,
    output logic [FIFO_ADDR_BITS:0] level
);

    localparam logic [FIFO_ADDR_BITS:0] ONE = {{FIFO_ADDR_BITS{1'b0}}, 1'b1};

    trace_rec_t              r_mem [2**FIFO_ADDR_BITS];
    logic [FIFO_ADDR_BITS:0] r_wr_cnt;
    logic [FIFO_ADDR_BITS:0] r_rd_cnt;

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (push) r_wr_cnt <= r_wr_cnt + ONE;
            if (pop)  r_rd_cnt <= r_rd_cnt + ONE;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_cnt[FIFO_ADDR_BITS-1:0]] <= din;
    end

    assign head  = r_mem[r_rd_cnt[FIFO_ADDR_BITS-1:0]];
    assign level = r_wr_cnt - r_rd_cnt;

endmodule

// File: rtl/bus_cycle_capture.sv
// bus_cycle_capture: records one entry per CPU bus cycle into a FIFO and
// streams each entry out as four bytes over a valid/ready handshake.
module bus_cycle_capture
    import trace_pkg::*;
#(
    parameter int FIFO_ADDR_BITS = 4
) (
    input  logic                    clk,
    input  logic                    resb,
    input  logic                    enable,
    input  logic                    cyc_valid,
    input  logic [15:0]             cyc_addr,
    input  logic [7:0]              cyc_data,
    input  logic                    cyc_rnw,
    input  logic                    cyc_sync,
    input  logic                    clr_ovf,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    overflow,
    output logic [FIFO_ADDR_BITS:0] level
);

    logic                w_cap;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    trace_rec_t          w_rec;
    trace_rec_t          w_head;
    trace_rec_t          r_rec;
    state_t              r_state;
    logic [SEQ_BITS-1:0] r_seq;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic                r_overflow;

    assign w_cap  = cyc_valid && enable;
    // level never exceeds depth, so its top bit alone marks full.
    assign w_full = level[FIFO_ADDR_BITS];
    assign w_push = w_cap && !w_full;
    assign w_pop  = (level != '0) && (r_state == ST_IDLE || (r_state == ST_B3 && tx_ready));
    assign w_rec  = '{seq: r_seq, sync: cyc_sync, rnw: cyc_rnw, addr: cyc_addr, data: cyc_data};

    trace_fifo #(.FIFO_ADDR_BITS(FIFO_ADDR_BITS)) u_fifo (
        .clk   (clk),
        .resb  (resb),
        .push  (w_push),
        .din   (w_rec),
        .pop   (w_pop),
        .head  (w_head),
        .level (level)
    );

    // Sequence advances on dropped captures too, so gaps show downstream.
    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            r_seq      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_cap) r_seq <= r_seq + SEQ_BITS'(1);
            if (w_cap && w_full) r_overflow <= 1'b1;
            else if (clr_ovf)    r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            r_state    <= ST_IDLE;
            r_rec      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else if (w_pop) begin
            r_state    <= ST_B0;
            r_rec      <= w_head;
            r_tx_data  <= w_head.data;
            r_tx_valid <= 1'b1;
        end else if (r_state != ST_IDLE && tx_ready) begin
            case (r_state)
                ST_B0: begin
                    r_state   <= ST_B1;
                    r_tx_data <= rec_byte(r_rec, BYTE_ADDR_LO);
                end
                ST_B1: begin
                    r_state   <= ST_B2;
                    r_tx_data <= rec_byte(r_rec, BYTE_ADDR_HI);
                end
                ST_B2: begin
                    r_state   <= ST_B3;
                    r_tx_data <= rec_byte(r_rec, BYTE_FLAGS);
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bus_cycle_capture.sv
// tb_bus_cycle_capture: directed vectors plus randomized traffic checked every
// cycle against a queue-based model of the capture/stream behaviour.
module tb_bus_cycle_capture;

    logic        clk = 1'b0;
    logic        resb = 1'b0;
    logic        enable = 1'b0;
    logic        cyc_valid = 1'b0;
    logic [15:0] cyc_addr = '0;
    logic [7:0]  cyc_data = '0;
    logic        cyc_rnw = 1'b0;
    logic        cyc_sync = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        overflow;
    logic [4:0]  level;

    always #5 clk = ~clk;

    bus_cycle_capture #(.FIFO_ADDR_BITS(4)) dut (
        .clk       (clk),
        .resb      (resb),
        .enable    (enable),
        .cyc_valid (cyc_valid),
        .cyc_addr  (cyc_addr),
        .cyc_data  (cyc_data),
        .cyc_rnw   (cyc_rnw),
        .cyc_sync  (cyc_sync),
        .clr_ovf   (clr_ovf),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .overflow  (overflow),
        .level     (level)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: stored records are a queue; the record being sent is a 32-bit word
    // whose byte i (little-endian) is stream byte Bi, with m_left bytes to go.
    logic [31:0] m_q[$];
    logic [31:0] m_cur;
    int          m_left;
    logic [5:0]  m_seq;
    logic        m_ovf;

    task automatic model_reset();
        m_q.delete();
        m_cur  = '0;
        m_left = 0;
        m_seq  = '0;
        m_ovf  = 1'b0;
    endtask

    always @(posedge clk) begin
        int  old;
        bit  cap;
        if (resb) begin
            old = m_q.size();
            cap = cyc_valid && enable;
            if (m_left == 0) begin
                if (old > 0) begin
                    m_cur  = m_q.pop_front();
                    m_left = 4;
                end
            end else if (tx_ready) begin
                m_left--;
                if (m_left == 0 && old > 0) begin
                    m_cur  = m_q.pop_front();
                    m_left = 4;
                end
            end
            if (cap) begin
                if (old < 16) m_q.push_back({m_seq, cyc_sync, cyc_rnw, cyc_addr, cyc_data});
                else m_ovf = 1'b1;
                m_seq++;
            end
            if (clr_ovf && !(cap && old >= 16)) m_ovf = 1'b0;
        end
    end

    bit          chk_en = 1'b0;
    int          max_level = 0;
    logic [7:0]  rx_q[$];

    always @(negedge clk) begin
        if (chk_en && resb) begin
            check("tx_valid", {31'd0, tx_valid}, {31'd0, m_left > 0});
            check("level", {27'd0, level}, m_q.size());
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            if (m_left > 0) check("tx_data", {24'd0, tx_data}, {24'd0, m_cur[8*(4-m_left) +: 8]});
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (int'(level) > max_level) max_level = int'(level);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [15:0] a, input logic [7:0] d, input logic rnw, input logic sync);
        enable    = 1'b1;
        cyc_valid = 1'b1;
        cyc_addr  = a;
        cyc_data  = d;
        cyc_rnw   = rnw;
        cyc_sync  = sync;
        tick();
        cyc_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        check("wait_bytes_done", {31'd0, rx_q.size() >= n}, 32'd1);
    endtask

    task automatic do_reset();
        resb = 1'b0;
        model_reset();
        tick();
        tick();
        resb = 1'b1;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rnw;
        logic        sync;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{16'hFFFC, 8'h34, 1'b1, 1'b0, 8'h34, 8'hFC, 8'hFF, 8'h01};
        vt[1] = '{16'h1234, 8'h56, 1'b1, 1'b1, 8'h56, 8'h34, 8'h12, 8'h07};
        vt[2] = '{16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h08};
        vt[3] = '{16'hFFFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
        vt[4] = '{16'h00FF, 8'h80, 1'b0, 1'b1, 8'h80, 8'hFF, 8'h00, 8'h12};
        vt[5] = '{16'h8800, 8'hA5, 1'b0, 1'b1, 8'hA5, 8'h00, 8'h88, 8'h16};

        model_reset();
        tick();
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_level", {27'd0, level}, 32'd0);
        tick();
        resb   = 1'b1;
        chk_en = 1'b1;

        // Directed records from reset: seq follows the table index.
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rx_q.delete();
            capture(vt[i].addr, vt[i].data, vt[i].rnw, vt[i].sync);
            if (i == 0) begin
                check("lat_pre_valid", {31'd0, tx_valid}, 32'd0);
                tick();
                check("lat_b0_valid", {31'd0, tx_valid}, 32'd1);
                check("lat_b0_data", {24'd0, tx_data}, 32'h34);
            end
            wait_bytes(4, 20);
            check($sformatf("vec%0d_b0", i), {24'd0, rx_q[0]}, {24'd0, vt[i].b0});
            check($sformatf("vec%0d_b1", i), {24'd0, rx_q[1]}, {24'd0, vt[i].b1});
            check($sformatf("vec%0d_b2", i), {24'd0, rx_q[2]}, {24'd0, vt[i].b2});
            check($sformatf("vec%0d_b3", i), {24'd0, rx_q[3]}, {24'd0, vt[i].b3});
            tick();
        end

        // One capture every 4 clk keeps up with the stream.
        rx_q.delete();
        max_level = 0;
        for (int i = 0; i < 100; i++) begin
            capture(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            repeat (3) tick();
        end
        wait_bytes(400, 40);
        repeat (4) tick();
        check("rate_bytes", rx_q.size(), 32'd400);
        check("rate_overflow", {31'd0, overflow}, 32'd0);
        check("rate_max_level", {31'd0, max_level <= 1}, 32'd1);

        // Stalled consumer: fill, drop, sticky overflow and clear priority.
        do_reset();
        tx_ready = 1'b0;
        rx_q.delete();
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc_valid = 1'b1;
            cyc_addr  = 16'(16'h4000 + i);
            cyc_data  = 8'(i);
            tick();
        end
        cyc_valid = 1'b0;
        check("full_level", {27'd0, level}, 32'd16);
        check("full_overflow", {31'd0, overflow}, 32'd1);
        cyc_valid = 1'b1;
        clr_ovf   = 1'b1;
        tick();
        cyc_valid = 1'b0;
        clr_ovf   = 1'b0;
        check("set_beats_clear", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clear_alone", {31'd0, overflow}, 32'd0);
        tx_ready = 1'b1;
        wait_bytes(68, 120);
        repeat (4) tick();
        check("drain_bytes", rx_q.size(), 32'd68);
        check("drain_seq15", {26'd0, rx_q[63][7:2]}, 32'd15);
        check("drain_seq16", {26'd0, rx_q[67][7:2]}, 32'd16);
        rx_q.delete();
        capture(16'h0001, 8'h02, 1'b1, 1'b0);
        wait_bytes(4, 20);
        check("seq_after_gap", {24'd0, rx_q[3]}, {24'd0, 6'd21, 1'b0, 1'b1});

        // Reset while the third byte of a record is on the bus.
        do_reset();
        tx_ready = 1'b1;
        capture(16'hBEEF, 8'h11, 1'b1, 1'b1);
        capture(16'hCAFE, 8'h22, 1'b0, 1'b0);
        tick();
        tick();
        tx_ready = 1'b0;
        check("b2_byte", {24'd0, tx_data}, 32'hBE);
        check("b2_level", {27'd0, level}, 32'd1);
        #2;
        resb = 1'b0;
        model_reset();
        #1;
        check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_level", {27'd0, level}, 32'd0);
        check("mid_rst_data", {24'd0, tx_data}, 32'd0);
        tick();
        tick();
        resb = 1'b1;
        tx_ready = 1'b1;
        rx_q.delete();
        capture(16'h2468, 8'h9C, 1'b0, 1'b1);
        wait_bytes(4, 20);
        check("post_rst_b0", {24'd0, rx_q[0]}, 32'h9C);
        check("post_rst_b1", {24'd0, rx_q[1]}, 32'h68);
        check("post_rst_b2", {24'd0, rx_q[2]}, 32'h24);
        check("post_rst_b3", {24'd0, rx_q[3]}, 32'h02);

        // Random traffic; the per-cycle model comparison does the checking.
        for (int i = 0; i < 3000; i++) begin
            bit stall_phase = ((i / 200) % 2) == 1;
            cyc_valid = ($urandom_range(0, 2) == 0);
            enable    = ($urandom_range(0, 7) != 0);
            cyc_addr  = 16'($urandom);
            cyc_data  = 8'($urandom);
            cyc_rnw   = 1'($urandom);
            cyc_sync  = 1'($urandom);
            clr_ovf   = ($urandom_range(0, 31) == 0);
            tx_ready  = stall_phase ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            tick();
        end
        cyc_valid = 1'b0;
        clr_ovf   = 1'b0;
        tx_ready  = 1'b1;
        begin
            int c = 0;
            while ((level != 0 || tx_valid) && c < 200) begin
                tick();
                c++;
            end
        end
        check("final_empty", {27'd0, level}, 32'd0);
        check("final_idle", {31'd0, tx_valid}, 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
